// File: rtl/debounce_edge_bank.sv
// debounce_edge_bank: per-channel synchroniser, debounce counter and edge detector.
//
// Each of the WIDTH raw asynchronous inputs passes through a SYNC_STAGES-deep
// synchroniser. The channel's debounced level moves to the new value only after
// DELAY consecutive cycles in which the synchronised input disagrees with it.
// Each change of the debounced level raises a one-cycle rising or falling pulse.
//
// Optional feature: define DEBOUNCE_EDGE_LATCH_EN to add sticky per-channel event
// flags, cleared by writing one to clr. Without the macro, events and irq are
// tied to 0 and clr is ignored.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   signal     - raw asynchronous channel inputs            [WIDTH]
//   clr        - write-one-to-clear for event flags         [WIDTH]
//   stable     - debounced level per channel, registered    [WIDTH]
//   is_rising  - one-cycle pulse on stable 0->1, registered [WIDTH]
//   is_falling - one-cycle pulse on stable 1->0, registered [WIDTH]
//   any_edge   - OR of all rising/falling pulses, combinational
//   events     - sticky per-channel edge flags              [WIDTH]
//   irq        - OR of all events bits
module debounce_edge_bank #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DELAY       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] is_rising,
  output logic [WIDTH-1:0] is_falling,
  output logic             any_edge,
  output logic [WIDTH-1:0] events,
  output logic             irq
);

  localparam int unsigned CNT_W = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] update;

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce counter: clears on agreement, counts on disagreement, and on the
  // DELAY-th disagreeing cycle commits the new level instead of counting further.
  always_comb begin
    update = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          update[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser chain, counters, debounced level and edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      stable     <= '0;
      is_rising  <= '0;
      is_falling <= '0;
    end else begin
      sync_q[0] <= signal;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable     <= stable ^ update;
      // The committed value is sync itself, so it also gives the edge direction.
      is_rising  <= update & sync;
      is_falling <= update & ~sync;
    end
  end

  assign any_edge = |(is_rising | is_falling);

`ifdef DEBOUNCE_EDGE_LATCH_EN
  // Sticky flags: a pulse seen this cycle sets the flag even if clr is also high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      events <= '0;
    end else begin
      events <= (events & ~clr) | is_rising | is_falling;
    end
  end

  assign irq = |events;
`else
  logic unused_clr;

  assign unused_clr = ^clr;
  assign events     = '0;
  assign irq        = 1'b0;
`endif

endmodule
